// File: rtl/wb_queue_pkg.sv
// ----------------------------------------------------------------------------
// wb_queue_pkg
// Shared definitions for the writeback queue and the register file it feeds.
//   AW          register address width (also the reg_file address width)
//   DW          data width (also the reg_file data width)
//   WB_DEPTH    default number of queue entries (power of two, >= 2)
//   wb_entry_t  one pending writeback: destination register plus result
//   ptr_width   index width needed to address DEPTH entries
// ----------------------------------------------------------------------------
package wb_queue_pkg;

    localparam int AW       = 6;
    localparam int DW       = 64;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

    // Never return zero so a pointer always has at least one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_queue_if.sv
// ----------------------------------------------------------------------------
// wb_queue_if
// Bus bundle around the writeback queue.
//   Producer A (ALU)        : a_valid, a_ready, a_addr, a_data
//   Producer B (load unit)  : b_valid, b_ready, b_addr, b_data
//   Retirement control      : wb_hold
//   reg_file write port     : wr_en, in_addr, in_data
//   Operand forwarding      : addr_r1/2 in, fwd_hit1/2 and fwd_data1/2 out
//   Status                  : count (occupied entries)
// Modports: slave = the queue itself, master = whatever drives producers,
// hold and read addresses and consumes the write/forward outputs.
// ----------------------------------------------------------------------------
interface wb_queue_if
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
);

    localparam int CW = ptr_width(DEPTH) + 1;

    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;

    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;

    logic          wb_hold;

    logic          wr_en;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;

    logic [AW-1:0] addr_r1;
    logic [AW-1:0] addr_r2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;

    logic [CW-1:0] count;

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  wb_hold, addr_r1, addr_r2,
        output a_ready, b_ready,
        output wr_en, in_addr, in_data,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
        output count
    );

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output wb_hold, addr_r1, addr_r2,
        input  a_ready, b_ready,
        input  wr_en, in_addr, in_data,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
        input  count
    );

endinterface

// File: rtl/wb_fwd_match.sv
// ----------------------------------------------------------------------------
// wb_fwd_match
// Combinational forwarding lookup over the queue storage for one read port.
//   entries  queue storage, indexed by slot
//   head     slot of the oldest occupied entry
//   count    number of occupied entries starting at head
//   addr     operand read address
//   hit      some occupied entry targets addr
//   data     data of the youngest such entry, zero when there is no hit
// Build option: WB_ZERO_REG_EN makes register 0 never produce a hit.
// ----------------------------------------------------------------------------
module wb_fwd_match
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  wb_entry_t [DEPTH-1:0]              entries,
    input  logic [ptr_width(DEPTH)-1:0]        head,
    input  logic [ptr_width(DEPTH):0]          count,
    input  logic [AW-1:0]                      addr,
    output logic                               hit,
    output logic [DW-1:0]                      data
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] idx;

    // Walk from oldest to youngest; a later match overwrites an earlier
    // one, so the youngest pending write to this register wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (entries[idx].addr == addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
`ifdef WB_ZERO_REG_EN
        if (addr == '0) begin
            hit  = 1'b0;
            data = '0;
        end
`endif
    end

endmodule

// File: rtl/wb_queue.sv
// ----------------------------------------------------------------------------
// wb_queue
// Writeback buffer in front of reg_file. Collects results from the ALU
// (port A, higher priority) and the load unit (port B), keeps them in
// program order, retires one per cycle onto the reg_file write port and
// forwards still-pending data to the two operand read ports.
//   clk   rising-edge clock
//   rst   asynchronous active-low reset; drops every pending entry
//   bus   wb_queue_if.slave (handshakes, write port, forwarding, count)
// Build option: WB_ZERO_REG_EN - results for register 0 are accepted but
// discarded, and register 0 never forwards.
// ----------------------------------------------------------------------------
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    wb_queue_if.slave  bus
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = CW + 1;

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [PW-1:0]         head_q;
    logic [PW-1:0]         tail_q;
    logic [CW-1:0]         count_q;

    logic          empty;
    logic          retire;
    logic [FW-1:0] free;
    logic          a_fire;
    logic          b_fire;
    logic          a_enq;
    logic          b_enq;
    logic [1:0]    enq_count;
    logic [PW-1:0] b_slot;

    assign empty  = (count_q == '0);
    assign retire = !empty && !bus.wb_hold;

    // A retiring head frees its slot in the same cycle, so a full queue
    // that is draining can still accept a new result.
    assign free = FW'(DEPTH) - FW'(count_q) + FW'(retire);

    // Port A owns the first free slot; B only gets in alongside A when
    // two slots are available.
    assign bus.a_ready = (free >= FW'(1));
    assign bus.b_ready = bus.a_valid ? (free >= FW'(2)) : (free >= FW'(1));

    assign a_fire = bus.a_valid && bus.a_ready;
    assign b_fire = bus.b_valid && bus.b_ready;

    // Register 0 writes complete the handshake but never occupy a slot.
`ifdef WB_ZERO_REG_EN
    assign a_enq = a_fire && (bus.a_addr != '0);
    assign b_enq = b_fire && (bus.b_addr != '0);
`else
    assign a_enq = a_fire;
    assign b_enq = b_fire;
`endif

    assign enq_count = {1'b0, a_enq} + {1'b0, b_enq};
    assign b_slot    = tail_q + PW'(a_enq);

    // Pointer and occupancy bookkeeping; reset empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(retire);
            tail_q  <= tail_q + PW'(enq_count);
            count_q <= count_q + CW'(enq_count) - CW'(retire);
        end
    end

    // Entry storage is deliberately left unreset; occupancy alone decides
    // which slots are meaningful. B lands behind A when both enqueue.
    always_ff @(posedge clk) begin
        if (a_enq) begin
            mem_q[tail_q] <= '{addr: bus.a_addr, data: bus.a_data};
        end
        if (b_enq) begin
            mem_q[b_slot] <= '{addr: bus.b_addr, data: bus.b_data};
        end
    end

    assign bus.wr_en   = retire;
    assign bus.in_addr = mem_q[head_q].addr;
    assign bus.in_data = mem_q[head_q].data;
    assign bus.count   = count_q;

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries (mem_q),
        .head    (head_q),
        .count   (count_q),
        .addr    (bus.addr_r1),
        .hit     (bus.fwd_hit1),
        .data    (bus.fwd_data1)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries (mem_q),
        .head    (head_q),
        .count   (count_q),
        .addr    (bus.addr_r2),
        .hit     (bus.fwd_hit2),
        .data    (bus.fwd_data2)
    );

endmodule
